// File: rtl/auth_req_sequencer_if.sv
// auth_req_sequencer_if
// Purpose: groups the CC lines, the host handshake and the status outputs of
//   auth_req_sequencer into one bundle.
// Signals:
//   CC1, CC2           CC lines from the port
//   resp_req_in        host acknowledge, active-low
//   Ack_out_resp       host response valid, active-high
//   auth_msg_resp_in   response message from the host; header is the top 32 bits
//   resp_req_out       request strobe to the host
//   auth_msg_resp_out  request message
//   cc_orient          0 = CC1 attach, 1 = CC2 attach
//   resp_hdr           captured response header
//   retry_cnt          retries used so far
//   busy, auth_ok, auth_fail  status
// Modports: slave = sequencer side, master = host/port side.
interface auth_req_sequencer_if #(
  parameter int MSG_LEN = 2080
);
  logic               CC1;
  logic               CC2;
  logic               resp_req_in;
  logic               Ack_out_resp;
  logic [MSG_LEN-1:0] auth_msg_resp_in;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_resp_out;
  logic               cc_orient;
  logic [31:0]        resp_hdr;
  logic [1:0]         retry_cnt;
  logic               busy;
  logic               auth_ok;
  logic               auth_fail;

  modport slave (
    input  CC1, CC2, resp_req_in, Ack_out_resp, auth_msg_resp_in,
    output resp_req_out, auth_msg_resp_out, cc_orient, resp_hdr,
           retry_cnt, busy, auth_ok, auth_fail
  );

  modport master (
    output CC1, CC2, resp_req_in, Ack_out_resp, auth_msg_resp_in,
    input  resp_req_out, auth_msg_resp_out, cc_orient, resp_hdr,
           retry_cnt, busy, auth_ok, auth_fail
  );
endinterface

// File: rtl/auth_req_sequencer.sv
// auth_req_sequencer
// Purpose: sequences one USB Type-C authentication exchange: debounces CC
//   attach, latches orientation, issues the auth request with timeout/retry,
//   captures and checks the response header, and reports pass/fail.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    auth_req_sequencer_if.slave (CC lines, host handshake, status)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | detached, waiting for CC1 ^ CC2
// S_DEBOUNCE | counting consecutive cycles of one stable CC pattern
// S_REQ      | request strobe high, waiting for host accept or timeout
// S_BACKOFF  | one-cycle strobe gap before the next attempt
// S_CHECK    | comparing the captured header
// S_DONE     | authentication passed, held until detach
// S_FAIL     | authentication failed, held until detach
module auth_req_sequencer #(
  parameter int         MSG_LEN       = 2080,
  parameter int         DEBOUNCE_CYC  = 16,
  parameter int         TIMEOUT_CYC   = 64,
  parameter int         MAX_RETRY     = 3,
  parameter logic [7:0] PROTO_VER     = 8'h01,
  parameter logic [7:0] REQ_TYPE      = 8'h81,
  parameter logic [7:0] EXP_RESP_TYPE = 8'h09
) (
  input logic                 clk,
  input logic                 reset,
  auth_req_sequencer_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CYC);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [MSG_LEN-1:0] REQ_MSG =
    {PROTO_VER, REQ_TYPE, 16'h0000, {(MSG_LEN-32){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_REQ, S_BACKOFF, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t        state;
  logic [1:0]    cc_pat;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] to_cnt;

  logic       attach;
  logic       accept;
  logic [1:0] cc_now;

  assign cc_now = {bus.CC1, bus.CC2};
  assign attach = bus.CC1 ^ bus.CC2;
  assign accept = !bus.resp_req_in && bus.Ack_out_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= S_IDLE;
      cc_pat                <= 2'b00;
      deb_cnt               <= '0;
      to_cnt                <= '0;
      bus.resp_req_out      <= 1'b0;
      bus.auth_msg_resp_out <= '0;
      bus.cc_orient         <= 1'b0;
      bus.resp_hdr          <= 32'h0;
      bus.retry_cnt         <= 2'd0;
      bus.busy              <= 1'b0;
      bus.auth_ok           <= 1'b0;
      bus.auth_fail         <= 1'b0;
    end else if (state != S_IDLE && !attach) begin
      // Detach aborts everything; resp_hdr and cc_orient keep their last values.
      state            <= S_IDLE;
      deb_cnt          <= '0;
      to_cnt           <= '0;
      bus.resp_req_out <= 1'b0;
      bus.retry_cnt    <= 2'd0;
      bus.busy         <= 1'b0;
      bus.auth_ok      <= 1'b0;
      bus.auth_fail    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (attach) begin
            state         <= S_DEBOUNCE;
            cc_pat        <= cc_now;
            deb_cnt       <= DW'(1);
            bus.retry_cnt <= 2'd0;
            bus.busy      <= 1'b1;
          end
        end
        S_DEBOUNCE: begin
          // A flip directly between the two attached patterns also restarts.
          if (cc_now != cc_pat) begin
            cc_pat  <= cc_now;
            deb_cnt <= DW'(1);
          end else if (deb_cnt == DEB_DONE) begin
            state                 <= S_REQ;
            bus.cc_orient         <= bus.CC2;
            bus.resp_req_out      <= 1'b1;
            bus.auth_msg_resp_out <= REQ_MSG;
            to_cnt                <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        S_REQ: begin
          // Accept is tested first so it wins over a same-cycle timeout.
          if (accept) begin
            state            <= S_CHECK;
            bus.resp_hdr     <= bus.auth_msg_resp_in[MSG_LEN-1 -: 32];
            bus.resp_req_out <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            bus.resp_req_out <= 1'b0;
            if (bus.retry_cnt < RETRY_MAX) begin
              state         <= S_BACKOFF;
              bus.retry_cnt <= bus.retry_cnt + 2'd1;
            end else begin
              state         <= S_FAIL;
              bus.auth_fail <= 1'b1;
              bus.busy      <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_BACKOFF: begin
          state            <= S_REQ;
          bus.resp_req_out <= 1'b1;
          to_cnt           <= '0;
        end
        S_CHECK: begin
          bus.busy <= 1'b0;
          if (bus.resp_hdr[31:24] == PROTO_VER &&
              bus.resp_hdr[23:16] == EXP_RESP_TYPE) begin
            state       <= S_DONE;
            bus.auth_ok <= 1'b1;
          end else begin
            state         <= S_FAIL;
            bus.auth_fail <= 1'b1;
          end
        end
        S_DONE, S_FAIL: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_auth_req_sequencer.sv
`ifndef MSG_LEN
`define MSG_LEN 2080
`endif

module tb_auth_req_sequencer;
  localparam int ML = `MSG_LEN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  auth_req_sequencer_if #(.MSG_LEN(ML)) bus ();

  auth_req_sequencer #(.MSG_LEN(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    bit orient;
  } req_exp_t;

  typedef struct {
    int          t;
    bit          ok;
    bit          fail;
    logic [31:0] hdr;
    logic [1:0]  retry;
    bit          orient;
  } res_exp_t;

  req_exp_t req_q[$];
  res_exp_t res_q[$];
  logic [ML-1:0] exp_msg;
  logic [31:0]   last_hdr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ML-1:0] rand_msg(input logic [31:0] hdr);
    logic [ML-1:0] m;
    m = '0;
    for (int i = 0; i < ML / 32; i++) m[i*32 +: 32] = $urandom;
    m[ML-1 -: 32] = hdr;
    return m;
  endfunction

  // Monitor: pops expectations when the DUT raises the request or a result.
  logic prev_req = 1'b0;
  logic prev_res = 1'b0;
  always @(negedge clk) begin : mon
    req_exp_t e;
    res_exp_t r;
    if (!reset) begin
      chk("ok_fail_exclusive", {63'd0, bus.auth_ok & bus.auth_fail}, 64'd0);
      if (bus.resp_req_out && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
        else begin
          e = req_q.pop_front();
          chk("req_time", 64'(cyc), 64'(e.t));
          chk("req_orient", {63'd0, bus.cc_orient}, {63'd0, e.orient});
          chk("req_msg", {63'd0, bus.auth_msg_resp_out == exp_msg}, 64'd1);
          chk("req_busy", {63'd0, bus.busy}, 64'd1);
        end
      end
      if ((bus.auth_ok || bus.auth_fail) && !prev_res) begin
        if (res_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          r = res_q.pop_front();
          chk("res_time", 64'(cyc), 64'(r.t));
          chk("res_ok", {63'd0, bus.auth_ok}, {63'd0, r.ok});
          chk("res_fail", {63'd0, bus.auth_fail}, {63'd0, r.fail});
          chk("res_hdr", {32'd0, bus.resp_hdr}, {32'd0, r.hdr});
          chk("res_retry", {62'd0, bus.retry_cnt}, {62'd0, r.retry});
          chk("res_orient", {63'd0, bus.cc_orient}, {63'd0, r.orient});
          chk("res_busy", {63'd0, bus.busy}, 64'd0);
        end
      end
    end
    prev_req <= bus.resp_req_out;
    prev_res <= bus.auth_ok | bus.auth_fail;
  end

  task automatic wait_rise(output bit got);
    int n;
    n = 0;
    while (bus.resp_req_out && n < 300) begin @(negedge clk); n++; end
    while (!bus.resp_req_out && n < 300) begin @(negedge clk); n++; end
    got = bus.resp_req_out;
    if (!got) chk("wait_req_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_accept(input logic [31:0] hdr, input int d, input int retries, input bit orient);
    bit good;
    res_exp_t r;
    good = (hdr[31:24] == 8'h01) && (hdr[23:16] == 8'h09);
    repeat (d) @(negedge clk);
    bus.resp_req_in      = 1'b0;
    bus.Ack_out_resp     = 1'b1;
    bus.auth_msg_resp_in = rand_msg(hdr);
    r.t = cyc + 2; r.ok = good; r.fail = !good; r.hdr = hdr;
    r.retry = 2'(retries); r.orient = orient;
    res_q.push_back(r);
    last_hdr = hdr;
    @(negedge clk);
    bus.resp_req_in      = 1'b1;
    bus.Ack_out_resp     = 1'b0;
    bus.auth_msg_resp_in = rand_msg($urandom);
  endtask

  task automatic detach_check(input bit orient);
    @(negedge clk);
    bus.CC1 = 1'b0;
    bus.CC2 = 1'b0;
    @(negedge clk);
    chk("detach_req", {63'd0, bus.resp_req_out}, 64'd0);
    chk("detach_ok", {63'd0, bus.auth_ok}, 64'd0);
    chk("detach_fail", {63'd0, bus.auth_fail}, 64'd0);
    chk("detach_busy", {63'd0, bus.busy}, 64'd0);
    chk("detach_retry", {62'd0, bus.retry_cnt}, 64'd0);
    chk("detach_hdr_kept", {32'd0, bus.resp_hdr}, {32'd0, last_hdr});
    chk("detach_orient_kept", {63'd0, bus.cc_orient}, {63'd0, orient});
    repeat (3) @(negedge clk);
  endtask

  // n_miss windows go unanswered (4 or more means the host never answers).
  task automatic run_session(input bit orient, input int n_miss, input logic [31:0] hdr,
                             input int d, input bit bounce);
    int t0, kmax;
    bit got, good;
    req_exp_t e;
    res_exp_t r;
    @(negedge clk);
    if (bounce) begin
      for (int p = 0; p < 10; p++) begin
        bus.CC1 = orient ? 1'b0 : ~p[0];
        bus.CC2 = orient ? ~p[0] : 1'b0;
        repeat (5) @(negedge clk);
      end
    end
    bus.CC1 = !orient;
    bus.CC2 = orient;
    t0 = cyc;
    kmax = (n_miss >= 4) ? 3 : n_miss;
    for (int k = 0; k <= kmax; k++) begin
      e.t = t0 + 17 + 65 * k; e.orient = orient;
      req_q.push_back(e);
    end
    if (n_miss >= 4) begin
      r.t = t0 + 17 + 65 * 3 + 64; r.ok = 1'b0; r.fail = 1'b1; r.hdr = last_hdr;
      r.retry = 2'd3; r.orient = orient;
      res_q.push_back(r);
    end
    for (int a = 0; a <= kmax; a++) begin
      wait_rise(got);
      if (!got) break;
      if (a == n_miss) do_accept(hdr, d, n_miss, orient);
      else begin
        // Valid without the active-low acknowledge must not be taken.
        repeat ($urandom_range(0, 50)) @(negedge clk);
        bus.Ack_out_resp = 1'b1;
        @(negedge clk);
        bus.Ack_out_resp = 1'b0;
      end
    end
    repeat ((n_miss >= 4) ? 70 : 4) @(negedge clk);
    good = (n_miss < 4) && (hdr[31:24] == 8'h01) && (hdr[23:16] == 8'h09);
    chk("hold_ok", {63'd0, bus.auth_ok}, {63'd0, good});
    chk("hold_fail", {63'd0, bus.auth_fail}, {63'd0, !good});
    detach_check(orient);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, {63'd0, bus.resp_req_out}, 64'd0);
    chk({tag, "_msg_zero"}, {63'd0, bus.auth_msg_resp_out == '0}, 64'd1);
    chk({tag, "_orient"}, {63'd0, bus.cc_orient}, 64'd0);
    chk({tag, "_hdr"}, {32'd0, bus.resp_hdr}, 64'd0);
    chk({tag, "_retry"}, {62'd0, bus.retry_cnt}, 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_ok"}, {63'd0, bus.auth_ok}, 64'd0);
    chk({tag, "_fail"}, {63'd0, bus.auth_fail}, 64'd0);
  endtask

  initial begin : stim
    bit got;
    req_exp_t e;
    int t0;
    logic [31:0] hdr;
    bus.CC1 = 1'b0;
    bus.CC2 = 1'b0;
    bus.resp_req_in = 1'b1;
    bus.Ack_out_resp = 1'b0;
    bus.auth_msg_resp_in = '0;
    exp_msg = {8'h01, 8'h81, 16'h0000, {(ML-32){1'b0}}};
    last_hdr = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    run_session(1'b0, 0, 32'h01090100, 5, 1'b0);   // good response on CC1
    run_session(1'b1, 0, 32'h017F0000, 10, 1'b0);  // wrong type on CC2
    run_session(1'b0, 4, 32'h01090000, 0, 1'b0);   // host never answers
    run_session(1'b0, 0, 32'h01095A5A, 20, 1'b1);  // bouncing attach
    run_session(1'b1, 1, 32'h0109ABCD, 63, 1'b0);  // accept on the timeout cycle
    run_session(1'b0, 3, 32'h0109FFFF, 0, 1'b0);   // last retry, immediate accept
    run_session(1'b1, 0, 32'h02090000, 7, 1'b0);   // wrong protocol version

    // Both CC lines high is not an attach.
    @(negedge clk);
    bus.CC1 = 1'b1;
    bus.CC2 = 1'b1;
    repeat (30) @(negedge clk);
    chk("both_cc_busy", {63'd0, bus.busy}, 64'd0);
    chk("both_cc_req", {63'd0, bus.resp_req_out}, 64'd0);
    bus.CC1 = 1'b0;
    bus.CC2 = 1'b0;
    repeat (3) @(negedge clk);

    // Detach during the second request window.
    bus.CC1 = 1'b1;
    t0 = cyc;
    e.orient = 1'b0;
    e.t = t0 + 17; req_q.push_back(e);
    e.t = t0 + 82; req_q.push_back(e);
    wait_rise(got);
    wait_rise(got);
    repeat (5) @(negedge clk);
    chk("mid_req_retry", {62'd0, bus.retry_cnt}, 64'd1);
    detach_check(1'b0);

    // Reset pulse in the middle of a request.
    @(negedge clk);
    bus.CC2 = 1'b1;
    t0 = cyc;
    e.orient = 1'b1;
    e.t = t0 + 17; req_q.push_back(e);
    wait_rise(got);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    last_hdr = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
    e.t = t0 + 17; req_q.push_back(e);
    wait_rise(got);
    do_accept(32'h01091234, 3, 0, 1'b1);
    repeat (4) @(negedge clk);
    chk("after_reset_ok", {63'd0, bus.auth_ok}, 64'd1);
    detach_check(1'b1);

    for (int i = 0; i < 8; i++) begin
      hdr = $urandom;
      if ($urandom_range(0, 1) == 1) hdr[31:16] = 16'h0109;
      run_session(1'($urandom_range(0, 1)), $urandom_range(0, 4), hdr,
                  $urandom_range(0, 63), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("res_queue_drained", 64'(res_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
